round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter RATING_WIDTH, default 8, the width of the rating counter.
REQ-002 SHALL have parameter CLK_PER_SEC, default 25_000_000, the number of clk cycles per countdown second.
REQ-003 SHALL have parameter COUNTDOWN_SEC, default 3, the pre-round countdown length in seconds (1..15).
REQ-004 SHALL have parameter REGEN_TIMEOUT, default 1024, the number of cycles to wait for i_ready before a regeneration retry.
REQ-005 SHALL have parameter HOLD_CYCLES, default 50_000_000, the banner hold time used by autostart.
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-008 SHALL have ports i_start_game and i_pause_game, input, 1 bit each, button levels.
REQ-009 SHALL have ports i_is_win and i_is_lose, input, 1 bit each, engine round outcome.
REQ-010 SHALL have port i_ready, input, 1 bit, level-regeneration-done status.
REQ-011 SHALL have port o_regenerate_level, output, 1 bit, the level regeneration request.
REQ-012 SHALL have port o_game_running, output, 1 bit; engines are unpaused while it is high.
REQ-013 SHALL have port o_image_number, output, 2 bits: 0 title, 1 win, 2 lose, 3 pause.
REQ-014 SHALL have port o_current_rating, output, RATING_WIDTH bits, the session rating.
REQ-015 SHALL have port o_countdown, output, 4 bits, the seconds remaining; 0 outside COUNTDOWN.

Function
REQ-016 SHALL implement the FSM states IDLE, REGEN, COUNTDOWN, RUN, PAUSED, WIN and LOSE.
REQ-017 SHALL detect button presses as rising edges using a one-flop history per button; levels SHALL be ignored.
REQ-018 SHALL decode all outputs from registered state only, with no combinational input-to-output path.
REQ-019 SHALL move IDLE->REGEN on a start edge; o_image_number SHALL be 0 in IDLE.
REQ-020 SHALL, in REGEN, assert o_regenerate_level and move to COUNTDOWN on the first cycle i_ready=1.
REQ-021 SHALL, after REGEN_TIMEOUT cycles without i_ready in REGEN, deassert o_regenerate_level for exactly 1 cycle, reload the timer and reassert it.
REQ-022 SHALL, in COUNTDOWN, load o_countdown=COUNTDOWN_SEC and decrement it every CLK_PER_SEC cycles, moving to RUN in the cycle after the counter would reach 0.
REQ-023 SHALL hold o_game_running=1 only in RUN.
REQ-024 SHALL, in RUN, apply this priority order: i_is_lose -> LOSE, then i_is_win -> WIN, then pause edge -> PAUSED; a simultaneous win and lose SHALL count as lose.
REQ-025 SHALL move PAUSED->RUN on a start edge; a pause edge in PAUSED SHALL be ignored; o_image_number SHALL be 3 in PAUSED.
REQ-026 SHALL increment the rating by 1 on entry to WIN, saturating at all-ones.
REQ-027 SHALL decrement the rating by 1 on entry to LOSE, saturating at 0.
REQ-028 SHALL change the rating exactly once per round outcome.
REQ-029 SHALL show o_image_number 1 in WIN and 2 in LOSE; a start edge in either state SHALL move to REGEN.
REQ-030 SHALL ignore i_is_win and i_is_lose outside RUN.
REQ-031 SHALL ignore button edges in REGEN and COUNTDOWN.
REQ-032 SHALL not wrap any counter; the timers SHALL be sized by $clog2 of their parameters.

Reset
REQ-033 SHALL, on rst_n=0 sampled at a clk edge, set state=IDLE, o_regenerate_level=0, o_game_running=0, o_image_number=0, o_current_rating=0, o_countdown=0, all timers=0 and button history=0.
REQ-034 SHALL abort any state on a mid-operation reset and keep no pending request.
REQ-035 SHALL not register a button held through reset as an edge when reset is released.

Configuration
REQ-036 SHALL, with macro ROUND_SEQ_AUTOSTART_EN defined, leave WIN automatically for REGEN after HOLD_CYCLES cycles with no start edge, while a start edge still leaves WIN immediately; LOSE SHALL be unaffected.
REQ-037 SHALL, without ROUND_SEQ_AUTOSTART_EN, leave WIN only on a start edge and contain no hold timer.

Verification (CLK_PER_SEC=4, COUNTDOWN_SEC=3, REGEN_TIMEOUT=8, HOLD_CYCLES=16)
REQ-038 SHALL verify that a start pulse in IDLE with i_ready rising 5 cycles later gives o_countdown sequence 3,2,1 of 4 cycles each, then o_game_running=1, with o_regenerate_level low once in COUNTDOWN.
REQ-039 SHALL verify that, with i_ready held at 0, o_regenerate_level shows a 1-cycle low every 9 cycles, and that i_ready=1 then gives COUNTDOWN.
REQ-040 SHALL verify that i_is_win and i_is_lose both high in RUN with rating 5 give rating 4 and o_image_number=2.
REQ-041 SHALL verify that win at rating 255 keeps rating 255, and that lose at rating 0 keeps rating 0.
REQ-042 SHALL verify that a pause edge in RUN gives o_game_running=0 and image 3, that a held pause gives no toggle, and that a start edge returns to RUN.
REQ-043 SHALL verify that, with ROUND_SEQ_AUTOSTART_EN, WIN with no button gives o_regenerate_level=1 after 16 cycles; that without the macro, WIN holds for 100 cycles; and that rst_n=0 in RUN gives all outputs 0 the next cycle.

Source files
------------

// File: rtl/round_sequencer_if.sv
// ---------------------------------------------------------------------------
// round_sequencer_if
// Groups the handshake and status signals between the round sequencer and the
// rest of the game: button levels, engine outcome, level regeneration and the
// display/status outputs.
//
// Parameter
//   RATING_WIDTH        width of o_current_rating
// Signals
//   i_start_game        start button level
//   i_pause_game        pause button level
//   i_is_win            engine reports the round won
//   i_is_lose           engine reports the round lost
//   i_ready             level regeneration finished
//   o_regenerate_level  level regeneration request
//   o_game_running      engines run while high
//   o_image_number      0 title, 1 win, 2 lose, 3 pause
//   o_current_rating    session rating
//   o_countdown         seconds left before the round starts
// Modports
//   master              game side: drives the i_* signals, reads the o_* signals
//   slave               sequencer side
// ---------------------------------------------------------------------------
interface round_sequencer_if #(
   parameter int RATING_WIDTH = 8
);
   logic                    i_start_game;
   logic                    i_pause_game;
   logic                    i_is_win;
   logic                    i_is_lose;
   logic                    i_ready;
   logic                    o_regenerate_level;
   logic                    o_game_running;
   logic [1:0]              o_image_number;
   logic [RATING_WIDTH-1:0] o_current_rating;
   logic [3:0]              o_countdown;

   modport master (
      output i_start_game, i_pause_game, i_is_win, i_is_lose, i_ready,
      input  o_regenerate_level, o_game_running, o_image_number,
             o_current_rating, o_countdown
   );

   modport slave (
      input  i_start_game, i_pause_game, i_is_win, i_is_lose, i_ready,
      output o_regenerate_level, o_game_running, o_image_number,
             o_current_rating, o_countdown
   );
endinterface

// File: rtl/round_sequencer.sv
// ---------------------------------------------------------------------------
// round_sequencer
// Game round controller: title screen, level regeneration with retry, pre-round
// countdown, running / paused play, and win / lose banners with a saturating
// session rating.
//
// Ports
//   clk    single clock
//   rst_n  synchronous active-low reset
//   bus    round_sequencer_if.slave (buttons, outcome, regen handshake, status)
//
// Optional feature
//   ROUND_SEQ_AUTOSTART_EN  when defined, the WIN banner leaves for REGEN by
//                           itself after HOLD_CYCLES cycles without a start edge.
//
// All outputs decode from registered state only.
// ---------------------------------------------------------------------------
module round_sequencer #(
   parameter int RATING_WIDTH  = 8,
   parameter int CLK_PER_SEC   = 25_000_000,
   parameter int COUNTDOWN_SEC = 3,
   parameter int REGEN_TIMEOUT = 1024,
   parameter int HOLD_CYCLES   = 50_000_000
) (
   input logic               clk,
   input logic               rst_n,
   round_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REGEN,
      S_COUNTDOWN,
      S_RUN,
      S_PAUSED,
      S_WIN,
      S_LOSE
   } state_e;

   localparam int SEC_W   = (CLK_PER_SEC   > 1) ? $clog2(CLK_PER_SEC)   : 1;
   localparam int REGEN_W = (REGEN_TIMEOUT > 1) ? $clog2(REGEN_TIMEOUT) : 1;
   localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(CLK_PER_SEC - 1);
   localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(REGEN_TIMEOUT - 1);
   localparam logic [3:0]         CD_LOAD    = 4'(COUNTDOWN_SEC);

`ifdef ROUND_SEQ_AUTOSTART_EN
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   logic [HOLD_W-1:0] hold_q, hold_d;
`endif

   state_e                  state_q, state_d;
   logic [SEC_W-1:0]        sec_q, sec_d;
   logic [REGEN_W-1:0]      regen_q, regen_d;
   logic                    gap_q, gap_d;
   logic [3:0]              cd_q, cd_d;
   logic [RATING_WIDTH-1:0] rating_q, rating_d;
   logic                    start_hist_q, pause_hist_q;
   logic                    armed_q;
   logic                    start_edge, pause_edge;

   // armed_q stays low for the first cycle after reset so a button held
   // through reset is absorbed into the history rather than seen as a press.
   assign start_edge = bus.i_start_game & ~start_hist_q & armed_q;
   assign pause_edge = bus.i_pause_game & ~pause_hist_q & armed_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sec_q        <= '0;
         regen_q      <= '0;
         gap_q        <= 1'b0;
         cd_q         <= '0;
         rating_q     <= '0;
         start_hist_q <= 1'b0;
         pause_hist_q <= 1'b0;
         armed_q      <= 1'b0;
`ifdef ROUND_SEQ_AUTOSTART_EN
         hold_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         sec_q        <= sec_d;
         regen_q      <= regen_d;
         gap_q        <= gap_d;
         cd_q         <= cd_d;
         rating_q     <= rating_d;
         start_hist_q <= bus.i_start_game;
         pause_hist_q <= bus.i_pause_game;
         armed_q      <= 1'b1;
`ifdef ROUND_SEQ_AUTOSTART_EN
         hold_q       <= hold_d;
`endif
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would infer a latch. Timers default to zero so
   // each state entry starts them from a clean value.
   always_comb begin
      state_d  = state_q;
      sec_d    = '0;
      regen_d  = '0;
      gap_d    = 1'b0;
      cd_d     = '0;
      rating_d = rating_q;
`ifdef ROUND_SEQ_AUTOSTART_EN
      hold_d   = '0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_edge) state_d = S_REGEN;
         end
         S_REGEN: begin
            if (bus.i_ready) begin
               state_d = S_COUNTDOWN;
               cd_d    = CD_LOAD;
            end else if (gap_q) begin
               // One-cycle request drop is over; timer restarts from zero.
               gap_d   = 1'b0;
            end else if (regen_q == REGEN_LAST) begin
               gap_d   = 1'b1;
            end else begin
               regen_d = regen_q + 1'b1;
            end
         end
         S_COUNTDOWN: begin
            cd_d = cd_q;
            if (sec_q == SEC_LAST) begin
               if (cd_q <= 4'd1) begin
                  state_d = S_RUN;
                  cd_d    = '0;
               end else begin
                  cd_d    = cd_q - 4'd1;
               end
            end else begin
               sec_d = sec_q + 1'b1;
            end
         end
         S_RUN: begin
            // Lose wins over win, so a simultaneous report counts as a loss.
            if (bus.i_is_lose) begin
               state_d = S_LOSE;
               if (rating_q != '0) rating_d = rating_q - 1'b1;
            end else if (bus.i_is_win) begin
               state_d = S_WIN;
               if (rating_q != '1) rating_d = rating_q + 1'b1;
            end else if (pause_edge) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (start_edge) state_d = S_RUN;
         end
         S_WIN: begin
            if (start_edge) begin
               state_d = S_REGEN;
`ifdef ROUND_SEQ_AUTOSTART_EN
            end else if (hold_q == HOLD_LAST) begin
               state_d = S_REGEN;
            end else begin
               hold_d  = hold_q + 1'b1;
`endif
            end
         end
         S_LOSE: begin
            if (start_edge) state_d = S_REGEN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.o_regenerate_level = (state_q == S_REGEN) && !gap_q;
   assign bus.o_game_running     = (state_q == S_RUN);
   assign bus.o_countdown        = cd_q;
   assign bus.o_current_rating   = rating_q;

   always_comb begin
      unique case (state_q)
         S_WIN:    bus.o_image_number = 2'd1;
         S_LOSE:   bus.o_image_number = 2'd2;
         S_PAUSED: bus.o_image_number = 2'd3;
         default:  bus.o_image_number = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_round_sequencer
// Self-checking bench for round_sequencer with small timing parameters. The
// reference model tracks the current phase and the number of cycles spent in
// it; regeneration gaps, countdown digits and images follow from that count
// by plain arithmetic. Define ROUND_SEQ_AUTOSTART_EN for both files to check
// the automatic WIN exit.
// ---------------------------------------------------------------------------
module tb_round_sequencer;

   localparam int CPS  = 4;
   localparam int CDS  = 3;
   localparam int RTO  = 8;
   localparam int HOLD = 16;
   localparam int RW   = 8;
   localparam int RMAX = (1 << RW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   round_sequencer_if #(.RATING_WIDTH(RW)) bus ();

   round_sequencer #(
      .RATING_WIDTH (RW),
      .CLK_PER_SEC  (CPS),
      .COUNTDOWN_SEC(CDS),
      .REGEN_TIMEOUT(RTO),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_REGEN, M_CD, M_RUN, M_PAUSED, M_WIN, M_LOSE} m_phase_e;

   m_phase_e m_phase    = M_IDLE;
   int       m_n        = 0;   // cycles spent in the current phase
   int       m_rating   = 0;
   bit       m_prev_s   = 0;
   bit       m_prev_p   = 0;
   bit       m_armed    = 0;

   task automatic enter(input m_phase_e ph);
      m_phase = ph;
      m_n     = 0;
   endtask

   task automatic model_step(input bit r, input bit s, input bit p,
                             input bit w, input bit l, input bit rdy);
      bit se, pe;
      if (!r) begin
         enter(M_IDLE);
         m_rating = 0;
         m_prev_s = 0;
         m_prev_p = 0;
         m_armed  = 0;
      end else begin
         se = s && !m_prev_s && m_armed;
         pe = p && !m_prev_p && m_armed;
         case (m_phase)
            M_IDLE:   if (se) enter(M_REGEN);
            M_REGEN:  if (rdy) enter(M_CD); else m_n++;
            M_CD:     if (m_n == CPS * CDS - 1) enter(M_RUN); else m_n++;
            M_RUN: begin
               if (l) begin
                  if (m_rating > 0) m_rating--;
                  enter(M_LOSE);
               end else if (w) begin
                  if (m_rating < RMAX) m_rating++;
                  enter(M_WIN);
               end else if (pe) begin
                  enter(M_PAUSED);
               end
            end
            M_PAUSED: if (se) enter(M_RUN);
            M_WIN: begin
               if (se) enter(M_REGEN);
`ifdef ROUND_SEQ_AUTOSTART_EN
               else if (m_n == HOLD - 1) enter(M_REGEN);
`endif
               else m_n++;
            end
            M_LOSE:   if (se) enter(M_REGEN);
            default:  enter(M_IDLE);
         endcase
         m_prev_s = s;
         m_prev_p = p;
         m_armed  = 1;
      end
   endtask

   function automatic int exp_regen();
      return (m_phase == M_REGEN && (m_n % (RTO + 1)) != RTO) ? 1 : 0;
   endfunction

   function automatic int exp_img();
      case (m_phase)
         M_WIN:    return 1;
         M_LOSE:   return 2;
         M_PAUSED: return 3;
         default:  return 0;
      endcase
   endfunction

   function automatic int exp_cd();
      return (m_phase == M_CD) ? CDS - m_n / CPS : 0;
   endfunction

   // One clock: drive inputs, let the edge happen, step the model, then
   // compare every output on the falling edge.
   task automatic cycle(input bit r, input bit s, input bit p,
                        input bit w, input bit l, input bit rdy);
      rst_n            = r;
      bus.i_start_game = s;
      bus.i_pause_game = p;
      bus.i_is_win     = w;
      bus.i_is_lose    = l;
      bus.i_ready      = rdy;
      @(posedge clk);
      model_step(r, s, p, w, l, rdy);
      @(negedge clk);
      check("regen",   bus.o_regenerate_level, exp_regen());
      check("running", bus.o_game_running,     (m_phase == M_RUN) ? 1 : 0);
      check("image",   bus.o_image_number,     exp_img());
      check("cd",      bus.o_countdown,        exp_cd());
      check("rating",  bus.o_current_rating,   m_rating);
   endtask

   task automatic tick(input bit s = 0, input bit p = 0, input bit w = 0,
                       input bit l = 0, input bit rdy = 0);
      cycle(1'b1, s, p, w, l, rdy);
   endtask

   task automatic do_reset();
      cycle(1'b0, 0, 0, 0, 0, 0);
      tick();
   endtask

   // From IDLE, WIN or LOSE: start, regenerate immediately, count down.
   task automatic to_run();
      tick(.s(1));
      tick(.rdy(1));
      repeat (CPS * CDS) tick();
      check("to_run", bus.o_game_running, 1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit r, s, p, w, l, rdy;
      int regen, run, img, cd, rating;
   } vec_t;

   vec_t vecs[8];

   initial begin
      bus.i_start_game = 0;
      bus.i_pause_game = 0;
      bus.i_is_win     = 0;
      bus.i_is_lose    = 0;
      bus.i_ready      = 0;

      // start held through reset and afterwards must not count as a press
      vecs[0] = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      vecs[1] = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      vecs[2] = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      vecs[3] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
      vecs[4] = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0};
      vecs[5] = '{1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0};
      vecs[6] = '{1, 0, 0, 0, 0, 1,  0, 0, 0, 3, 0};
      vecs[7] = '{1, 1, 0, 1, 1, 0,  0, 0, 0, 3, 0};

      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].w, vecs[i].l, vecs[i].rdy);
         check("vec_regen",  bus.o_regenerate_level, vecs[i].regen);
         check("vec_run",    bus.o_game_running,     vecs[i].run);
         check("vec_img",    bus.o_image_number,     vecs[i].img);
         check("vec_cd",     bus.o_countdown,        vecs[i].cd);
         check("vec_rating", bus.o_current_rating,   vecs[i].rating);
      end

      // countdown 3,2,1 of CPS cycles each after ready arrives 5 cycles late
      do_reset();
      tick(.s(1));
      repeat (4) tick();
      tick(.rdy(1));
      check("cd_first", bus.o_countdown, 3);
      check("cd_regen_low", bus.o_regenerate_level, 0);
      for (int i = 1; i < CPS * CDS; i++) begin
         tick();
         check("cd_seq", bus.o_countdown, CDS - i / CPS);
      end
      tick();
      check("cd_done_run", bus.o_game_running, 1);
      check("cd_done_zero", bus.o_countdown, 0);

      // regeneration retry: one low cycle every RTO+1 cycles
      do_reset();
      tick(.s(1));
      check("regen_first", bus.o_regenerate_level, 1);
      for (int i = 1; i < 3 * (RTO + 1); i++) begin
         tick();
         check("regen_gap", bus.o_regenerate_level, ((i % (RTO + 1)) != RTO) ? 1 : 0);
      end
      tick(.rdy(1));
      check("regen_to_cd", bus.o_countdown, CDS);

      // rating: lose at 0, build to 5, simultaneous outcome, saturate at max
      do_reset();
      to_run();
      tick(.l(1));
      check("lose_at_zero", bus.o_current_rating, 0);
      check("lose_img", bus.o_image_number, 2);
      repeat (5) begin
         to_run();
         tick(.w(1));
      end
      check("rating_five", bus.o_current_rating, 5);
      to_run();
      tick(.w(1), .l(1));
      check("both_rating", bus.o_current_rating, 4);
      check("both_img", bus.o_image_number, 2);
      for (int k = 4; k < RMAX; k++) begin
         to_run();
         tick(.w(1));
      end
      check("rating_max", bus.o_current_rating, RMAX);
      to_run();
      tick(.w(1));
      check("win_at_max", bus.o_current_rating, RMAX);
      check("win_img", bus.o_image_number, 1);
      tick(.l(1));
      check("lose_outside_run", bus.o_current_rating, RMAX);

      // pause / resume
      to_run();
      tick(.p(1));
      check("pause_run", bus.o_game_running, 0);
      check("pause_img", bus.o_image_number, 3);
      repeat (3) tick(.p(1));
      check("pause_held", bus.o_image_number, 3);
      tick();
      tick(.p(1));
      check("pause_in_paused", bus.o_image_number, 3);
      tick(.s(1));
      check("resume_run", bus.o_game_running, 1);

      // WIN banner hold
      tick(.w(1));
`ifdef ROUND_SEQ_AUTOSTART_EN
      repeat (HOLD - 1) tick();
      check("hold_still_win", bus.o_image_number, 1);
      tick();
      check("autostart_regen", bus.o_regenerate_level, 1);
      tick(.rdy(1));
      repeat (CPS * CDS) tick();
`else
      repeat (100) tick();
      check("win_held_img", bus.o_image_number, 1);
      check("win_held_regen", bus.o_regenerate_level, 0);
      tick(.s(1));
      tick(.rdy(1));
      repeat (CPS * CDS) tick();
`endif

      // reset in RUN clears everything on the next cycle
      check("before_rst_run", bus.o_game_running, 1);
      cycle(1'b0, 0, 0, 0, 0, 0);
      check("rst_regen",  bus.o_regenerate_level, 0);
      check("rst_run",    bus.o_game_running, 0);
      check("rst_img",    bus.o_image_number, 0);
      check("rst_cd",     bus.o_countdown, 0);
      check("rst_rating", bus.o_current_rating, 0);
      tick();

      // randomized traffic against the model
      begin
         bit s_lvl = 0;
         bit p_lvl = 0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) s_lvl = ~s_lvl;
            if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
            cycle(($urandom_range(0, 399) != 0),
                  s_lvl, p_lvl,
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 4) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
